multi_clock_generate: RTL and testbench
=======================================

Name: multi_clock_generate

Overview:
- Multi-channel, runtime-programmable clock/tick generator, clocked from the board system clock.
- Each of N_CH channels divides s_clk by a programmable count and runs in one of two modes:
  - TOGGLE: 50 % duty square wave.
  - PULSE: single-cycle tick, usable as a clock enable.
- Next generation of the fixed half-second divider: parametrised channel count and width, runtime divisor/mode writes, per-channel enable, and exact period with no extra-cycle slip.
- Feeds display multiplexing, blink and debounce timers in the lab top levels.

Parameters:
- N_CH, 4, number of independent channels.
- CNT_W, 26, counter and divisor width in bits.
- DEF_DIV, 24999999, reset divisor for every channel (0.5 s half-period at 50 MHz).
- DEF_MODE, 0, reset mode for every channel (0 = TOGGLE, 1 = PULSE).
- CH_W, derived localparam = max(1, clog2(N_CH)); width of the channel index.

Ports:
- s_clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  N_CH  per-channel run enable, level-sensitive.
- cfg_wr  input  1  one-cycle configuration write strobe.
- cfg_ch  input  CH_W  channel index for the write.
- cfg_div  input  CNT_W  divisor value D for the write.
- cfg_mode  input  1  mode for the write (0 = TOGGLE, 1 = PULSE).
- cfg_pending  output  N_CH  channel has a written config not yet applied.
- clk_out  output  N_CH  TOGGLE-mode square wave; 0 in PULSE mode.
- tick_out  output  N_CH  PULSE-mode one-cycle tick; 0 in TOGGLE mode.

Behaviour:
- Clock and reset: one clock (s_clk). Reset is asynchronous and active-low (rst_n). All state is cleared on rst_n low, independent of s_clk.
- Reset values:
  - cnt = 0 and active div = DEF_DIV.
  - Active mode = DEF_MODE.
  - Pending regs = DEF_DIV / DEF_MODE, pending flag = 0.
  - cfg_pending = 0, clk_out = 0, tick_out = 0.
- Per channel: counter cnt, active divisor/mode, pending divisor/mode, pending flag. All outputs are registered.
- Counting when en = 1:
  - If cnt == active div: cnt <= 0 and a wrap event occurs.
  - Otherwise cnt <= cnt + 1.
  - Wrap period is exactly D+1 s_clk cycles.
- TOGGLE mode: clk_out inverts on the edge where the wrap is taken, giving a period of 2(D+1) cycles at 50 % duty. tick_out = 0.
- PULSE mode: tick_out = 1 for exactly the cycle following the wrap edge, 0 otherwise, giving one tick per D+1 cycles. clk_out = 0.
- First output after enable:
  - After en rises with cnt = 0, the first wrap occurs on the (D+1)th enabled edge.
  - TOGGLE: clk_out first goes 1 after D+1 cycles.
  - PULSE: first tick is asserted D+1 cycles after en rises.
- Disable: en = 0 synchronously forces cnt <= 0, clk_out <= 0 and tick_out <= 0 on the next edge, including mid-period.
- D = 0: TOGGLE gives s_clk/2. PULSE holds tick_out continuously 1 while enabled.
- Configuration write:
  - On cfg_wr with cfg_ch < N_CH: pending div/mode are written and the pending flag is set.
  - cfg_ch >= N_CH: the write is ignored, no state changes.
  - A second write while a config is pending overwrites it; last write wins.
- Applying a pending config:
  - Applied on the first wrap edge after the flag was set, or on the next edge if en = 0 (disabled channel).
  - On apply: active <= pending, flag cleared, cnt <= 0.
  - If the mode changes on apply, clk_out <= 0 and tick_out <= 0; the new mode starts clean.
  - If the mode is unchanged, the TOGGLE inversion or PULSE tick of that wrap still occurs.
- Simultaneous events:
  - cfg_wr in the same cycle as a wrap on that channel: the wrap applies the previously pending value, if any.
  - The new write becomes pending and is applied at the following wrap.
  - When clear and set coincide, the flag stays set.
- Channels are fully independent. No cross-channel phase alignment is guaranteed.

Decomposition:
- Shared package `clkgen_pkg`:
  - Mode constants MODE_TOGGLE = 1'b0 and MODE_PULSE = 1'b1.
  - Default-divisor constants for the common rates: 1 Hz, 2 Hz, 1 kHz at 50 MHz.
- One sub-module `clkgen_channel`: a single channel's counter, active/pending registers and output flops, with a write-strobe input.
- Top level `multi_clock_generate` decodes cfg_ch into per-channel strobes and instantiates N_CH channels in a generate loop.

Test Plan:
- Reset: drive rst_n low asynchronously mid-cycle with N_CH = 4 -> all outputs and cfg_pending 0 immediately; after release with en = 0, outputs stay 0.
- TOGGLE, D = 3, en = 1 on channel 0 -> clk_out[0] rises 4 cycles after en, then toggles every 4 cycles (period 8, duty 50 %); 100 periods checked.
- PULSE, D = 4 on channel 1 -> tick_out[1] high for exactly 1 of every 5 cycles, first tick 5 cycles after en; D = 0 -> tick_out[1] held at 1.
- Runtime change on channel 2 running TOGGLE D = 9:
  - Write D = 2 mid-period -> cfg_pending[2] = 1 until the next wrap, then period 6.
  - Write to cfg_ch = 5 -> ignored.
- Collision: cfg_wr on the exact wrap edge of channel 3 -> new divisor applied one wrap later; double write before wrap -> second value wins.
- Disable mid-period: en[0] dropped at cnt = 2 of D = 7 -> clk_out[0] 0 next cycle; re-enable -> first toggle after exactly 8 cycles. Mode change TOGGLE->PULSE -> clk_out forced 0, no stray tick.

Source files
------------

// File: rtl/clkgen_pkg.sv
// Shared constants for the programmable clock/tick generator: mode encodings,
// common divisor values at 50 MHz and the channel-index width helper.
package clkgen_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Divisors D at 50 MHz: TOGGLE gives 50e6 / (2(D+1)), PULSE ticks every D+1 cycles.
    localparam int unsigned DIV_1HZ  = 24_999_999;
    localparam int unsigned DIV_2HZ  = 12_499_999;
    localparam int unsigned DIV_1KHZ = 24_999;

    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/clkgen_channel.sv
// One generator channel: wrap counter, active and pending divisor/mode,
// and registered TOGGLE / PULSE outputs.
module clkgen_channel
    import clkgen_pkg::*;
#(
    parameter int   CNT_W    = 26,
    parameter int   DEF_DIV  = 24999999,
    parameter logic DEF_MODE = MODE_TOGGLE
) (
    input  logic             s_clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             mode_i,
    output logic             pending_o,
    output logic             clk_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic             mode_q, mode_d;
    logic             pmode_q, pmode_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wrap;
    logic             apply;

    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            div_q   <= CNT_W'(DEF_DIV);
            pdiv_q  <= CNT_W'(DEF_DIV);
            mode_q  <= DEF_MODE;
            pmode_q <= DEF_MODE;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pdiv_q  <= pdiv_d;
            mode_q  <= mode_d;
            pmode_q <= pmode_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign wrap  = en_i && (cnt_q == div_q);
    // A disabled channel has no phase to preserve, so it takes new config at once.
    assign apply = pend_q && (wrap || !en_i);

    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        div_d   = div_q;
        mode_d  = mode_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        pdiv_d  = wr_i ? div_i : pdiv_q;
        pmode_d = wr_i ? mode_i : pmode_q;
        // A write landing on the apply edge re-arms the flag for the next wrap.
        pend_d  = wr_i || (pend_q && !apply);

        if (apply) begin
            div_d  = pdiv_q;
            mode_d = pmode_q;
        end

        if (!en_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (wrap) begin
            cnt_d = '0;
            if (apply && (pmode_q != mode_q)) begin
                clk_d = 1'b0;
            end else if (mode_q == MODE_TOGGLE) begin
                clk_d = ~clk_q;
            end else begin
                clk_d  = 1'b0;
                tick_d = 1'b1;
            end
        end
    end

    assign pending_o = pend_q;
    assign clk_o     = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/multi_clock_generate.sv
// Multi-channel programmable clock/tick generator: decodes configuration
// writes into per-channel strobes and replicates the channel N_CH times.
module multi_clock_generate
    import clkgen_pkg::*;
#(
    parameter int   N_CH     = 4,
    parameter int   CNT_W    = 26,
    parameter int   DEF_DIV  = 24999999,
    parameter logic DEF_MODE = MODE_TOGGLE,
    localparam int  CH_W     = ch_width(N_CH)
) (
    input  logic             s_clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  en,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_mode,
    output logic [N_CH-1:0]  cfg_pending,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick_out
);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic wr_ch;
            // Indices >= N_CH match no channel, so such writes are dropped.
            assign wr_ch = cfg_wr && (cfg_ch == CH_W'(gi));

            clkgen_channel #(
                .CNT_W    (CNT_W),
                .DEF_DIV  (DEF_DIV),
                .DEF_MODE (DEF_MODE)
            ) u_ch (
                .s_clk     (s_clk),
                .rst_n     (rst_n),
                .en_i      (en[gi]),
                .wr_i      (wr_ch),
                .div_i     (cfg_div),
                .mode_i    (cfg_mode),
                .pending_o (cfg_pending[gi]),
                .clk_o     (clk_out[gi]),
                .tick_o    (tick_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_clock_generate.sv
// Directed self-checking bench for multi_clock_generate (4-channel main
// instance plus a 5-channel instance for out-of-range channel writes).
module tb_multi_clock_generate;

    localparam int CNT_W = 26;

    logic              s_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        en = '0;
    logic              cfg_wr = 1'b0;
    logic [1:0]        cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic              cfg_mode = 1'b0;
    logic [3:0]        cfg_pending, clk_out, tick_out;

    logic [4:0]        en5 = '0;
    logic              wr5 = 1'b0;
    logic [2:0]        ch5 = '0;
    logic [CNT_W-1:0]  div5 = '0;
    logic              mode5 = 1'b0;
    logic [4:0]        pend5, co5, to5;

    int n_cmp = 0;
    int n_err = 0;

    always #5 s_clk = ~s_clk;

    multi_clock_generate #(.N_CH(4), .CNT_W(CNT_W)) dut (
        .s_clk(s_clk), .rst_n(rst_n), .en(en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_pending(cfg_pending),
        .clk_out(clk_out), .tick_out(tick_out)
    );

    multi_clock_generate #(.N_CH(5), .CNT_W(CNT_W)) dut5 (
        .s_clk(s_clk), .rst_n(rst_n), .en(en5), .cfg_wr(wr5), .cfg_ch(ch5),
        .cfg_div(div5), .cfg_mode(mode5), .cfg_pending(pend5),
        .clk_out(co5), .tick_out(to5)
    );

    task automatic step();
        @(posedge s_clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int div, input logic mode);
        cfg_wr   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_div  = CNT_W'(div);
        cfg_mode = mode;
        step();
        cfg_wr   = 1'b0;
    endtask

    task automatic test_reset();
        en = '0;
        cfg_write(0, 0, 1'b0);
        step();
        en = 4'b0101;
        cfg_write(2, 5, 1'b1);
        step();
        step();
        n_cmp++;
        if (clk_out[0] !== 1'b1) begin
            n_err++; $display("FAIL reset_pre_clk0 got=%b exp=1", clk_out[0]);
        end
        n_cmp++;
        if (cfg_pending !== 4'b0100) begin
            n_err++; $display("FAIL reset_pre_pending got=%b exp=0100", cfg_pending);
        end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cfg_pending, clk_out, tick_out} !== 12'h000) begin
            n_err++; $display("FAIL reset_async got pend=%b clk=%b tick=%b exp=0",
                              cfg_pending, clk_out, tick_out);
        end
        en = '0;
        step();
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++;
            if ({cfg_pending, clk_out, tick_out} !== 12'h000) begin
                n_err++; $display("FAIL reset_release cyc=%0d pend=%b clk=%b tick=%b exp=0",
                                  i, cfg_pending, clk_out, tick_out);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_toggle();
        cfg_write(0, 3, 1'b0);
        step();
        n_cmp++;
        if (cfg_pending[0] !== 1'b0) begin
            n_err++; $display("FAIL toggle_apply_disabled got=%b exp=0", cfg_pending[0]);
        end
        en[0] = 1'b1;
        for (int i = 1; i <= 800; i++) begin
            step();
            n_cmp++;
            if (clk_out[0] !== 1'(((i / 4) % 2)) || tick_out[0] !== 1'b0) begin
                n_err++; $display("FAIL toggle_d3 cyc=%0d clk=%b tick=%b exp_clk=%0d exp_tick=0",
                                  i, clk_out[0], tick_out[0], (i / 4) % 2);
            end
        end
        en[0] = 1'b0;
        step();
        $display("test_toggle done");
    endtask

    task automatic test_pulse();
        cfg_write(1, 4, 1'b1);
        step();
        en[1] = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            step();
            n_cmp++;
            if (tick_out[1] !== 1'(i % 5 == 0) || clk_out[1] !== 1'b0) begin
                n_err++; $display("FAIL pulse_d4 cyc=%0d tick=%b clk=%b exp_tick=%0d",
                                  i, tick_out[1], clk_out[1], i % 5 == 0);
            end
        end
        en[1] = 1'b0;
        step();
        cfg_write(1, 0, 1'b1);
        step();
        en[1] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            n_cmp++;
            if (tick_out[1] !== 1'b1) begin
                n_err++; $display("FAIL pulse_d0 cyc=%0d tick=%b exp=1", i, tick_out[1]);
            end
        end
        en[1] = 1'b0;
        step();
        n_cmp++;
        if (tick_out[1] !== 1'b0) begin
            n_err++; $display("FAIL pulse_disable tick=%b exp=0", tick_out[1]);
        end
        $display("test_pulse done");
    endtask

    task automatic test_runtime();
        cfg_write(2, 9, 1'b0);
        step();
        en[2] = 1'b1;
        for (int i = 1; i <= 13; i++) step();
        cfg_write(2, 2, 1'b0);
        for (int i = 15; i <= 20; i++) begin
            n_cmp++;
            if (cfg_pending[2] !== 1'b1 || clk_out[2] !== 1'b1) begin
                n_err++; $display("FAIL runtime_pending cyc=%0d pend=%b clk=%b exp=1/1",
                                  i, cfg_pending[2], clk_out[2]);
            end
            step();
        end
        n_cmp++;
        if (cfg_pending[2] !== 1'b0 || clk_out[2] !== 1'b0) begin
            n_err++; $display("FAIL runtime_apply pend=%b clk=%b exp=0/0", cfg_pending[2], clk_out[2]);
        end
        for (int j = 1; j <= 24; j++) begin
            step();
            n_cmp++;
            if (clk_out[2] !== 1'(((j / 3) % 2))) begin
                n_err++; $display("FAIL runtime_d2 cyc=%0d clk=%b exp=%0d", j, clk_out[2], (j / 3) % 2);
            end
        end
        en[2] = 1'b0;
        step();
        // Out-of-range channel index on the 5-channel instance, then a valid one.
        wr5 = 1'b1; ch5 = 3'd5; div5 = CNT_W'(7); mode5 = 1'b1;
        step();
        ch5 = 3'd7;
        step();
        wr5 = 1'b0;
        n_cmp++;
        if (pend5 !== 5'b00000 || co5 !== 5'b0 || to5 !== 5'b0) begin
            n_err++; $display("FAIL ignore_ch5 pend=%b clk=%b tick=%b exp=0", pend5, co5, to5);
        end
        wr5 = 1'b1; ch5 = 3'd4;
        step();
        wr5 = 1'b0;
        n_cmp++;
        if (pend5 !== 5'b10000) begin
            n_err++; $display("FAIL write_ch4 pend=%b exp=10000", pend5);
        end
        step();
        n_cmp++;
        if (pend5 !== 5'b00000) begin
            n_err++; $display("FAIL apply_ch4 pend=%b exp=00000", pend5);
        end
        $display("test_runtime done");
    endtask

    task automatic test_collision();
        cfg_write(3, 4, 1'b0);
        step();
        en[3] = 1'b1;
        for (int i = 1; i <= 4; i++) step();
        cfg_write(3, 6, 1'b0);
        n_cmp++;
        if (clk_out[3] !== 1'b1 || cfg_pending[3] !== 1'b1) begin
            n_err++; $display("FAIL collide_wrap clk=%b pend=%b exp=1/1", clk_out[3], cfg_pending[3]);
        end
        for (int i = 6; i <= 10; i++) begin
            step();
            n_cmp++;
            if (clk_out[3] !== 1'(i < 10) || cfg_pending[3] !== 1'(i < 10)) begin
                n_err++; $display("FAIL collide_old_div cyc=%0d clk=%b pend=%b exp=%0d",
                                  i, clk_out[3], cfg_pending[3], i < 10);
            end
        end
        for (int j = 1; j <= 7; j++) begin
            step();
            n_cmp++;
            if (clk_out[3] !== 1'(j == 7)) begin
                n_err++; $display("FAIL collide_new_div cyc=%0d clk=%b exp=%0d", j, clk_out[3], j == 7);
            end
        end
        cfg_write(3, 2, 1'b0);
        cfg_write(3, 1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step();
            n_cmp++;
            if (cfg_pending[3] !== 1'(i < 5) || clk_out[3] !== 1'(i < 5)) begin
                n_err++; $display("FAIL double_write_wait cyc=%0d pend=%b clk=%b exp=%0d",
                                  i, cfg_pending[3], clk_out[3], i < 5);
            end
        end
        for (int j = 1; j <= 8; j++) begin
            step();
            n_cmp++;
            if (clk_out[3] !== 1'(((j / 2) % 2))) begin
                n_err++; $display("FAIL double_write_d1 cyc=%0d clk=%b exp=%0d", j, clk_out[3], (j / 2) % 2);
            end
        end
        en[3] = 1'b0;
        step();
        $display("test_collision done");
    endtask

    task automatic test_disable_mode();
        cfg_write(0, 7, 1'b0);
        step();
        en[0] = 1'b1;
        for (int i = 1; i <= 10; i++) step();
        n_cmp++;
        if (clk_out[0] !== 1'b1) begin
            n_err++; $display("FAIL disable_pre clk=%b exp=1", clk_out[0]);
        end
        en[0] = 1'b0;
        step();
        n_cmp++;
        if (clk_out[0] !== 1'b0) begin
            n_err++; $display("FAIL disable_mid clk=%b exp=0", clk_out[0]);
        end
        en[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            n_cmp++;
            if (clk_out[0] !== 1'(i == 8)) begin
                n_err++; $display("FAIL reenable cyc=%0d clk=%b exp=%0d", i, clk_out[0], i == 8);
            end
        end
        cfg_write(0, 2, 1'b1);
        for (int i = 2; i <= 8; i++) begin
            step();
            n_cmp++;
            if (clk_out[0] !== 1'(i < 8) || tick_out[0] !== 1'b0) begin
                n_err++; $display("FAIL mode_change cyc=%0d clk=%b tick=%b exp_clk=%0d exp_tick=0",
                                  i, clk_out[0], tick_out[0], i < 8);
            end
        end
        for (int j = 1; j <= 9; j++) begin
            step();
            n_cmp++;
            if (tick_out[0] !== 1'(j % 3 == 0) || clk_out[0] !== 1'b0) begin
                n_err++; $display("FAIL new_pulse cyc=%0d tick=%b clk=%b exp_tick=%0d",
                                  j, tick_out[0], clk_out[0], j % 3 == 0);
            end
        end
        en[0] = 1'b0;
        step();
        $display("test_disable_mode done");
    endtask

    initial begin
        #23 rst_n = 1'b1;
        step();
        test_reset();
        test_toggle();
        test_pulse();
        test_runtime();
        test_collision();
        test_disable_mode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
